// File: rtl/tl_bank_router_if.sv
`default_nettype none
// ============================================================================
// Module   : tl_bank_router_if
// Brief    : Bundle of the client-side A/C/D/E socket and the per-bank
//            A/C/D/E ports of the TileLink bank router.
// Revision : 1.0 - initial release
// ============================================================================
interface tl_bank_router_if #(
   parameter int NBANKS = 4,
   parameter int SINK_W = 4,
   parameter int A_W    = 160,
   parameter int C_W    = 152,
   parameter int D_W    = 80
);
   // A channel
   logic                   up_a_valid_i;
   logic                   up_a_ready_o;
   logic [A_W-1:0]         up_a_msg_i;
   logic [NBANKS-1:0]      bank_a_valid_o;
   logic [NBANKS-1:0]      bank_a_ready_i;
   logic [A_W-1:0]         bank_a_msg_o;
   // C channel
   logic                   up_c_valid_i;
   logic                   up_c_ready_o;
   logic [C_W-1:0]         up_c_msg_i;
   logic [NBANKS-1:0]      bank_c_valid_o;
   logic [NBANKS-1:0]      bank_c_ready_i;
   logic [C_W-1:0]         bank_c_msg_o;
   // D channel
   logic [NBANKS-1:0]      bank_d_valid_i;
   logic [NBANKS-1:0]      bank_d_ready_o;
   logic [NBANKS*D_W-1:0]  bank_d_msg_i;
   logic                   up_d_valid_o;
   logic                   up_d_ready_i;
   logic [D_W-1:0]         up_d_msg_o;
   // E channel
   logic                   up_e_valid_i;
   logic                   up_e_ready_o;
   logic [SINK_W-1:0]      up_e_sink_i;
   logic [NBANKS-1:0]      bank_e_valid_o;
   logic [NBANKS-1:0]      bank_e_ready_i;
   logic [SINK_W-1:0]      bank_e_sink_o;

   // Client and bank models drive the inputs of the router
   modport master (
      output up_a_valid_i, up_a_msg_i, bank_a_ready_i,
      output up_c_valid_i, up_c_msg_i, bank_c_ready_i,
      output bank_d_valid_i, bank_d_msg_i, up_d_ready_i,
      output up_e_valid_i, up_e_sink_i, bank_e_ready_i,
      input  up_a_ready_o, bank_a_valid_o, bank_a_msg_o,
      input  up_c_ready_o, bank_c_valid_o, bank_c_msg_o,
      input  bank_d_ready_o, up_d_valid_o, up_d_msg_o,
      input  up_e_ready_o, bank_e_valid_o, bank_e_sink_o
   );

   // The router itself
   modport slave (
      input  up_a_valid_i, up_a_msg_i, bank_a_ready_i,
      input  up_c_valid_i, up_c_msg_i, bank_c_ready_i,
      input  bank_d_valid_i, bank_d_msg_i, up_d_ready_i,
      input  up_e_valid_i, up_e_sink_i, bank_e_ready_i,
      output up_a_ready_o, bank_a_valid_o, bank_a_msg_o,
      output up_c_ready_o, bank_c_valid_o, bank_c_msg_o,
      output bank_d_ready_o, up_d_valid_o, up_d_msg_o,
      output up_e_ready_o, bank_e_valid_o, bank_e_sink_o
   );
endinterface
`default_nettype wire

// File: rtl/tl_bank_router.sv
`default_nettype none
// ============================================================================
// Module   : tl_bank_router
// Brief    : Routes one coherent TileLink client socket onto NBANKS
//            line-interleaved L2 banks. A/C are steered by address with
//            burst locking, D is merged round-robin with message locking and
//            its sink tagged with the bank index, E is steered by that tag.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// tl_bank_router_req : address steering for one request channel (A or C).
// A multi-beat data message is pinned to the bank of its first beat.
// ----------------------------------------------------------------------------
module tl_bank_router_req #(
   parameter int         NBANKS   = 4,
   parameter int         BANK_W   = 2,
   parameter int         BEAT_LG  = 3,
   parameter logic [2:0] DATA_OP0 = 3'd0,
   parameter logic [2:0] DATA_OP1 = 3'd1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   input  logic [2:0]        opcode_i,
   input  logic [3:0]        size_i,
   input  logic [BANK_W-1:0] bank_i,
   output logic              ready_o,
   output logic [NBANKS-1:0] bank_valid_o,
   input  logic [NBANKS-1:0] bank_ready_i
);
   // Beats following the first one of a message of this size
   function automatic logic [7:0] f_rem_beats(input logic [3:0] size);
      logic [15:0] b;
      if (size > 4'(BEAT_LG)) b = 16'd1 << (size - 4'(BEAT_LG));
      else                    b = 16'd1;
      return 8'(b - 16'd1);
   endfunction

   logic              lock_q, lock_d;
   logic [BANK_W-1:0] bank_q, bank_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [BANK_W-1:0] w_target;
   logic              w_fire;
   logic              w_is_data;
   logic [7:0]        w_first_rem;

   // Steer to the locked bank mid-burst, otherwise to the address bank
   always_comb begin
      w_target     = lock_q ? bank_q : bank_i;
      ready_o      = 1'b0;
      bank_valid_o = '0;
      if (!rst_i) begin
         ready_o                = bank_ready_i[w_target];
         bank_valid_o[w_target] = valid_i;
      end
      w_fire      = valid_i && ready_o;
      w_is_data   = (opcode_i == DATA_OP0) || (opcode_i == DATA_OP1);
      w_first_rem = f_rem_beats(size_i);
   end

   // Burst lock: set on the first beat of a long data message, cleared on its last
   always_comb begin
      lock_d = lock_q;
      bank_d = bank_q;
      cnt_d  = cnt_q;
      if (w_fire) begin
         if (!lock_q) begin
            if (w_is_data && (w_first_rem != 8'd0)) begin
               lock_d = 1'b1;
               bank_d = w_target;
               cnt_d  = w_first_rem;
            end
         end else begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) lock_d = 1'b0;
         end
      end
   end

   // Lock state registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lock_q <= 1'b0;
         bank_q <= '0;
         cnt_q  <= 8'd0;
      end else begin
         lock_q <= lock_d;
         bank_q <= bank_d;
         cnt_q  <= cnt_d;
      end
   end
endmodule

// ----------------------------------------------------------------------------
// tl_bank_router : top level
// ----------------------------------------------------------------------------
module tl_bank_router #(
   parameter int NBANKS   = 4,
   parameter int ADDR_W   = 64,
   parameter int SINK_W   = 4,
   parameter int LINE_OFF = 6,
   parameter int BEAT_LG  = 3,
   parameter int A_W      = 160,
   parameter int C_W      = 152,
   parameter int D_W      = 80
) (
   input  logic            clk_i,
   input  logic            rst_i,
   tl_bank_router_if.slave bus
);
   localparam int BANK_W   = $clog2(NBANKS);
   // Bank bits sit LINE_OFF bits into the address field; clamp keeps the
   // select inside the address field for degenerate configurations.
   localparam int BANK_LSB = (LINE_OFF + BANK_W <= ADDR_W) ? 7 + LINE_OFF : 7;
   // Top BANK_W bits of the D sink field carry the bank index upstream
   localparam int TAG_LSB  = 7 + SINK_W - BANK_W;

   function automatic logic [7:0] f_rem_beats(input logic [3:0] size);
      logic [15:0] b;
      if (size > 4'(BEAT_LG)) b = 16'd1 << (size - 4'(BEAT_LG));
      else                    b = 16'd1;
      return 8'(b - 16'd1);
   endfunction

   // ------------------------------------------------------------------ A / C
   logic [A_W-1:0] w_a_msg;
   logic [C_W-1:0] w_c_msg;

   assign w_a_msg          = bus.up_a_msg_i;
   assign w_c_msg          = bus.up_c_msg_i;
   assign bus.bank_a_msg_o = w_a_msg;
   assign bus.bank_c_msg_o = w_c_msg;

   tl_bank_router_req #(
      .NBANKS   (NBANKS),
      .BANK_W   (BANK_W),
      .BEAT_LG  (BEAT_LG),
      .DATA_OP0 (3'd0),
      .DATA_OP1 (3'd1)
   ) u_a_route (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .valid_i      (bus.up_a_valid_i),
      .opcode_i     (w_a_msg[2:0]),
      .size_i       (w_a_msg[6:3]),
      .bank_i       (w_a_msg[BANK_LSB +: BANK_W]),
      .ready_o      (bus.up_a_ready_o),
      .bank_valid_o (bus.bank_a_valid_o),
      .bank_ready_i (bus.bank_a_ready_i)
   );

   tl_bank_router_req #(
      .NBANKS   (NBANKS),
      .BANK_W   (BANK_W),
      .BEAT_LG  (BEAT_LG),
      .DATA_OP0 (3'd5),
      .DATA_OP1 (3'd7)
   ) u_c_route (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .valid_i      (bus.up_c_valid_i),
      .opcode_i     (w_c_msg[2:0]),
      .size_i       (w_c_msg[6:3]),
      .bank_i       (w_c_msg[BANK_LSB +: BANK_W]),
      .ready_o      (bus.up_c_ready_o),
      .bank_valid_o (bus.bank_c_valid_o),
      .bank_ready_i (bus.bank_c_ready_i)
   );

   // ---------------------------------------------------------------------- D
   logic              d_lock_q, d_lock_d;
   logic [BANK_W-1:0] d_grant_q, d_grant_d;
   logic [BANK_W-1:0] d_ptr_q, d_ptr_d;
   logic [7:0]        d_cnt_q, d_cnt_d;

   logic [BANK_W-1:0] w_arb_idx;
   logic [BANK_W-1:0] w_scan_idx;
   logic              w_arb_any;
   logic [BANK_W-1:0] w_d_grant;
   logic              w_d_valid;
   logic              w_d_fire;
   logic              w_d_is_data;
   logic [7:0]        w_d_first_rem;
   logic [D_W-1:0]    w_d_sel;
   logic [D_W-1:0]    w_d_msg;

   // Round-robin search: scanning down so the smallest offset from the pointer wins
   always_comb begin
      w_arb_idx  = d_ptr_q;
      w_arb_any  = 1'b0;
      w_scan_idx = d_ptr_q;
      for (int i = NBANKS - 1; i >= 0; i--) begin
         w_scan_idx = d_ptr_q + BANK_W'(i);
         if (bus.bank_d_valid_i[w_scan_idx]) begin
            w_arb_idx = w_scan_idx;
            w_arb_any = 1'b1;
         end
      end
   end

   // Grant mux, sink tagging and the per-bank ready return path
   always_comb begin
      w_d_grant     = d_lock_q ? d_grant_q : w_arb_idx;
      w_d_valid     = d_lock_q ? bus.bank_d_valid_i[w_d_grant] : w_arb_any;
      w_d_sel       = bus.bank_d_msg_i[int'(w_d_grant) * D_W +: D_W];
      w_d_msg       = w_d_sel;
      w_d_msg[TAG_LSB +: BANK_W] = w_d_grant;
      w_d_is_data   = (w_d_sel[2:0] == 3'd1) || (w_d_sel[2:0] == 3'd5);
      w_d_first_rem = f_rem_beats(w_d_sel[6:3]);
      w_d_fire      = w_d_valid && bus.up_d_ready_i && !rst_i;

      bus.up_d_valid_o   = w_d_valid && !rst_i;
      bus.up_d_msg_o     = w_d_msg;
      bus.bank_d_ready_o = '0;
      if (w_d_valid && !rst_i) bus.bank_d_ready_o[w_d_grant] = bus.up_d_ready_i;
   end

   // Grant hold/lock and pointer advance once a whole message has gone up
   always_comb begin
      d_lock_d  = d_lock_q;
      d_grant_d = d_grant_q;
      d_cnt_d   = d_cnt_q;
      d_ptr_d   = d_ptr_q;
      if (w_d_fire) begin
         if (d_cnt_q == 8'd0) begin
            if (w_d_is_data && (w_d_first_rem != 8'd0)) begin
               d_lock_d  = 1'b1;
               d_grant_d = w_d_grant;
               d_cnt_d   = w_d_first_rem;
            end else begin
               d_lock_d = 1'b0;
               d_ptr_d  = w_d_grant + BANK_W'(1);
            end
         end else begin
            d_cnt_d = d_cnt_q - 8'd1;
            if (d_cnt_q == 8'd1) begin
               d_lock_d = 1'b0;
               d_ptr_d  = w_d_grant + BANK_W'(1);
            end
         end
      end else if (w_d_valid && !d_lock_q) begin
         // Stalled offer: keep it stable until the client takes it
         d_lock_d  = 1'b1;
         d_grant_d = w_d_grant;
      end
   end

   // D merge state registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         d_lock_q  <= 1'b0;
         d_grant_q <= '0;
         d_cnt_q   <= 8'd0;
         d_ptr_q   <= '0;
      end else begin
         d_lock_q  <= d_lock_d;
         d_grant_q <= d_grant_d;
         d_cnt_q   <= d_cnt_d;
         d_ptr_q   <= d_ptr_d;
      end
   end

   // ---------------------------------------------------------------------- E
   logic [BANK_W-1:0] w_e_target;

   // E steering on the bank tag carried in the top sink bits
   always_comb begin
      w_e_target         = bus.up_e_sink_i[SINK_W-1 -: BANK_W];
      bus.bank_e_valid_o = '0;
      bus.up_e_ready_o   = 1'b0;
      if (!rst_i) begin
         bus.bank_e_valid_o[w_e_target] = bus.up_e_valid_i;
         bus.up_e_ready_o               = bus.bank_e_ready_i[w_e_target];
      end
      bus.bank_e_sink_o = bus.up_e_sink_i;
   end
endmodule
`default_nettype wire

// File: tb/tb_tl_bank_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_tl_bank_router
// Brief    : Self-checking bench for tl_bank_router: directed scenarios plus
//            randomized traffic against a message-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tl_bank_router;
   localparam int NBANKS   = 4;
   localparam int ADDR_W   = 64;
   localparam int SINK_W   = 4;
   localparam int LINE_OFF = 6;
   localparam int BEAT_LG  = 3;
   localparam int A_W      = 160;
   localparam int C_W      = 152;
   localparam int D_W      = 80;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   errors = 0;
   int   checks = 0;

   tl_bank_router_if #(
      .NBANKS(NBANKS), .SINK_W(SINK_W), .A_W(A_W), .C_W(C_W), .D_W(D_W)
   ) bus ();

   tl_bank_router #(
      .NBANKS(NBANKS), .ADDR_W(ADDR_W), .SINK_W(SINK_W), .LINE_OFF(LINE_OFF),
      .BEAT_LG(BEAT_LG), .A_W(A_W), .C_W(C_W), .D_W(D_W)
   ) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   // ---------------------------------------------------------------- helpers
   function automatic int beats(input int sz);
      return (sz > BEAT_LG) ? (1 << (sz - BEAT_LG)) : 1;
   endfunction

   function automatic logic [A_W-1:0] mk_req(input int op, input int sz, input logic [ADDR_W-1:0] addr);
      logic [A_W-1:0] m;
      m = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      m[2:0]        = 3'(op);
      m[6:3]        = 4'(sz);
      m[ADDR_W+6:7] = addr;
      return m;
   endfunction

   function automatic logic [D_W-1:0] mk_d(input int op, input int sz, input int sink);
      logic [95:0]    r;
      logic [D_W-1:0] m;
      r = {$urandom(), $urandom(), $urandom()};
      m = r[D_W-1:0];
      m[2:0]  = 3'(op);
      m[6:3]  = 4'(sz);
      m[10:7] = 4'(sink);
      return m;
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_idle();
      bus.up_a_valid_i   = 1'b0;
      bus.up_a_msg_i     = '0;
      bus.bank_a_ready_i = '0;
      bus.up_c_valid_i   = 1'b0;
      bus.up_c_msg_i     = '0;
      bus.bank_c_ready_i = '0;
      bus.bank_d_valid_i = '0;
      bus.bank_d_msg_i   = '0;
      bus.up_d_ready_i   = 1'b0;
      bus.up_e_valid_i   = 1'b0;
      bus.up_e_sink_i    = '0;
      bus.bank_e_ready_i = '0;
   endtask

   task automatic do_reset();
      set_idle();
      rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
   endtask

   // ------------------------------------------------------------------ tests
   task automatic test_reset();
      tick();
      bus.up_a_valid_i   = 1'b1;
      bus.bank_a_ready_i = 4'hF;
      bus.up_c_valid_i   = 1'b1;
      bus.bank_c_ready_i = 4'hF;
      bus.bank_d_valid_i = 4'hF;
      bus.up_d_ready_i   = 1'b1;
      bus.up_e_valid_i   = 1'b1;
      bus.bank_e_ready_i = 4'hF;
      rst_i = 1'b1;
      #1;
      checks++; if (bus.up_a_ready_o !== 1'b0) begin errors++; $display("FAIL reset_a_ready: got %b expected 0", bus.up_a_ready_o); end
      checks++; if (bus.bank_a_valid_o !== 4'h0) begin errors++; $display("FAIL reset_a_valid: got %b expected 0000", bus.bank_a_valid_o); end
      checks++; if (bus.up_c_ready_o !== 1'b0) begin errors++; $display("FAIL reset_c_ready: got %b expected 0", bus.up_c_ready_o); end
      checks++; if (bus.bank_c_valid_o !== 4'h0) begin errors++; $display("FAIL reset_c_valid: got %b expected 0000", bus.bank_c_valid_o); end
      checks++; if (bus.up_d_valid_o !== 1'b0) begin errors++; $display("FAIL reset_d_valid: got %b expected 0", bus.up_d_valid_o); end
      checks++; if (bus.bank_d_ready_o !== 4'h0) begin errors++; $display("FAIL reset_d_ready: got %b expected 0000", bus.bank_d_ready_o); end
      checks++; if (bus.up_e_ready_o !== 1'b0) begin errors++; $display("FAIL reset_e_ready: got %b expected 0", bus.up_e_ready_o); end
      checks++; if (bus.bank_e_valid_o !== 4'h0) begin errors++; $display("FAIL reset_e_valid: got %b expected 0000", bus.bank_e_valid_o); end
   endtask

   task automatic test_a_get();
      do_reset();
      tick();
      bus.up_a_msg_i     = mk_req(4, 6, 64'h1040);
      bus.up_a_valid_i   = 1'b1;
      bus.bank_a_ready_i = 4'b0010;
      #1;
      checks++; if (bus.bank_a_valid_o !== 4'b0010) begin errors++; $display("FAIL a_get_valid: got %b expected 0010", bus.bank_a_valid_o); end
      checks++; if (bus.up_a_ready_o !== 1'b1) begin errors++; $display("FAIL a_get_ready: got %b expected 1", bus.up_a_ready_o); end
      bus.bank_a_ready_i = 4'b1101;
      #1;
      checks++; if (bus.up_a_ready_o !== 1'b0) begin errors++; $display("FAIL a_get_not_ready: got %b expected 0", bus.up_a_ready_o); end
   endtask

   task automatic test_c_burst();
      do_reset();
      bus.bank_c_ready_i = 4'hF;
      for (int b = 0; b < 8; b++) begin
         tick();
         bus.up_c_msg_i   = C_W'(mk_req(7, 6, (b == 0) ? 64'h00C0 : 64'h0));
         bus.up_c_valid_i = 1'b1;
         #1;
         checks++; if (bus.bank_c_valid_o !== 4'b1000) begin errors++; $display("FAIL c_burst_beat%0d: got %b expected 1000", b + 1, bus.bank_c_valid_o); end
      end
      tick();
      bus.up_c_msg_i = C_W'(mk_req(6, 6, 64'h0));
      #1;
      checks++; if (bus.bank_c_valid_o !== 4'b0001) begin errors++; $display("FAIL c_after_burst: got %b expected 0001", bus.bank_c_valid_o); end
   endtask

   task automatic test_d_pair();
      int left0;
      int left2;
      int exp_g;
      do_reset();
      left0 = 8;
      left2 = 8;
      bus.up_d_ready_i = 1'b1;
      bus.bank_d_msg_i[0*D_W +: D_W] = mk_d(5, 6, 2);
      bus.bank_d_msg_i[2*D_W +: D_W] = mk_d(5, 6, 1);
      for (int cyc = 0; cyc < 16; cyc++) begin
         tick();
         bus.bank_d_valid_i = {1'b0, left2 > 0, 1'b0, left0 > 0};
         #1;
         exp_g = (cyc < 8) ? 0 : 2;
         checks++; if (bus.bank_d_ready_o !== 4'(1 << exp_g)) begin errors++; $display("FAIL d_pair_grant_cyc%0d: got %b expected bank %0d", cyc, bus.bank_d_ready_o, exp_g); end
         checks++; if (bus.up_d_msg_o[10:7] !== ((exp_g == 0) ? 4'h2 : 4'h9)) begin errors++; $display("FAIL d_pair_sink_cyc%0d: got %h expected %h", cyc, bus.up_d_msg_o[10:7], (exp_g == 0) ? 4'h2 : 4'h9); end
         if (exp_g == 0) left0--; else left2--;
      end
      tick();
      bus.bank_d_msg_i[0*D_W +: D_W] = mk_d(0, 0, 0);
      bus.bank_d_msg_i[3*D_W +: D_W] = mk_d(0, 0, 0);
      bus.bank_d_valid_i = 4'b1001;
      #1;
      checks++; if (bus.bank_d_ready_o !== 4'b1000) begin errors++; $display("FAIL d_pair_ptr: got %b expected 1000", bus.bank_d_ready_o); end
   endtask

   task automatic test_e();
      logic [3:0] pats [4];
      pats[0] = 4'b1000; pats[1] = 4'b0111; pats[2] = 4'b1111; pats[3] = 4'b0000;
      do_reset();
      for (int p = 0; p < 4; p++) begin
         tick();
         bus.up_e_valid_i   = 1'b1;
         bus.up_e_sink_i    = 4'hC;
         bus.bank_e_ready_i = pats[p];
         #1;
         checks++; if (bus.bank_e_valid_o !== 4'b1000) begin errors++; $display("FAIL e_valid: got %b expected 1000", bus.bank_e_valid_o); end
         checks++; if (bus.up_e_ready_o !== pats[p][3]) begin errors++; $display("FAIL e_ready: got %b expected %b", bus.up_e_ready_o, pats[p][3]); end
         checks++; if (bus.bank_e_sink_o !== 4'hC) begin errors++; $display("FAIL e_sink: got %h expected c", bus.bank_e_sink_o); end
      end
   endtask

   task automatic test_reset_midburst();
      do_reset();
      bus.bank_d_msg_i[1*D_W +: D_W] = mk_d(5, 6, 3);
      bus.up_d_ready_i = 1'b1;
      repeat (3) begin
         tick();
         bus.bank_d_valid_i = 4'b0010;
      end
      rst_i = 1'b1;
      #1;
      checks++; if (bus.up_d_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_d_valid: got %b expected 0", bus.up_d_valid_o); end
      checks++; if (bus.bank_d_ready_o !== 4'h0) begin errors++; $display("FAIL midrst_d_ready: got %b expected 0000", bus.bank_d_ready_o); end
      tick();
      bus.bank_d_valid_i = 4'b1100;
      bus.bank_d_msg_i[2*D_W +: D_W] = mk_d(0, 0, 1);
      bus.bank_d_msg_i[3*D_W +: D_W] = mk_d(0, 0, 1);
      tick();
      rst_i = 1'b0;
      #1;
      checks++; if (bus.up_d_valid_o !== 1'b1) begin errors++; $display("FAIL postrst_d_valid: got %b expected 1", bus.up_d_valid_o); end
      checks++; if (bus.bank_d_ready_o !== 4'b0100) begin errors++; $display("FAIL postrst_grant: got %b expected 0100", bus.bank_d_ready_o); end
      checks++; if (bus.up_d_msg_o[10:7] !== 4'h9) begin errors++; $display("FAIL postrst_sink: got %h expected 9", bus.up_d_msg_o[10:7]); end
   endtask

   // A, C and E together with random traffic; the model tracks each
   // channel's outstanding burst as (bank, beats still to come).
   task automatic test_random_ac_e();
      int a_bank, a_left, c_bank, c_left;
      int aop, asz, cop, csz, tgt;
      logic [ADDR_W-1:0] aaddr, caddr;
      logic [A_W-1:0] am;
      logic [C_W-1:0] cm;
      logic [3:0] ardy, crdy, erdy, esink, exp_v;
      logic av, cv, ev, exp_r;
      do_reset();
      a_left = 0; a_bank = 0; c_left = 0; c_bank = 0;
      for (int n = 0; n < 600; n++) begin
         tick();
         av = ($urandom_range(0, 3) != 0);
         aop = $urandom_range(0, 7); asz = $urandom_range(0, 8);
         aaddr = {$urandom(), $urandom()};
         ardy = 4'($urandom_range(0, 15));
         am = mk_req(aop, asz, aaddr);
         cv = ($urandom_range(0, 3) != 0);
         cop = $urandom_range(0, 7); csz = $urandom_range(0, 8);
         caddr = {$urandom(), $urandom()};
         crdy = 4'($urandom_range(0, 15));
         cm = C_W'(mk_req(cop, csz, caddr));
         ev = $urandom_range(0, 1) != 0;
         esink = 4'($urandom_range(0, 15));
         erdy = 4'($urandom_range(0, 15));
         bus.up_a_valid_i = av; bus.up_a_msg_i = am; bus.bank_a_ready_i = ardy;
         bus.up_c_valid_i = cv; bus.up_c_msg_i = cm; bus.bank_c_ready_i = crdy;
         bus.up_e_valid_i = ev; bus.up_e_sink_i = esink; bus.bank_e_ready_i = erdy;
         #1;
         // A
         tgt = (a_left > 0) ? a_bank : int'(aaddr[LINE_OFF +: 2]);
         exp_v = av ? 4'(1 << tgt) : 4'h0;
         exp_r = ardy[tgt];
         checks++; if (bus.bank_a_valid_o !== exp_v) begin errors++; $display("FAIL rnd_a_valid n=%0d: got %b expected %b", n, bus.bank_a_valid_o, exp_v); end
         checks++; if (bus.up_a_ready_o !== exp_r) begin errors++; $display("FAIL rnd_a_ready n=%0d: got %b expected %b", n, bus.up_a_ready_o, exp_r); end
         checks++; if (bus.bank_a_msg_o !== am) begin errors++; $display("FAIL rnd_a_msg n=%0d: got %h expected %h", n, bus.bank_a_msg_o, am); end
         if (av && exp_r) begin
            if (a_left > 0) a_left--;
            else if ((aop == 0 || aop == 1) && beats(asz) > 1) begin a_left = beats(asz) - 1; a_bank = tgt; end
         end
         // C
         tgt = (c_left > 0) ? c_bank : int'(caddr[LINE_OFF +: 2]);
         exp_v = cv ? 4'(1 << tgt) : 4'h0;
         exp_r = crdy[tgt];
         checks++; if (bus.bank_c_valid_o !== exp_v) begin errors++; $display("FAIL rnd_c_valid n=%0d: got %b expected %b", n, bus.bank_c_valid_o, exp_v); end
         checks++; if (bus.up_c_ready_o !== exp_r) begin errors++; $display("FAIL rnd_c_ready n=%0d: got %b expected %b", n, bus.up_c_ready_o, exp_r); end
         checks++; if (bus.bank_c_msg_o !== cm) begin errors++; $display("FAIL rnd_c_msg n=%0d: got %h expected %h", n, bus.bank_c_msg_o, cm); end
         if (cv && exp_r) begin
            if (c_left > 0) c_left--;
            else if ((cop == 5 || cop == 7) && beats(csz) > 1) begin c_left = beats(csz) - 1; c_bank = tgt; end
         end
         // E
         tgt = int'(esink[3:2]);
         exp_v = ev ? 4'(1 << tgt) : 4'h0;
         checks++; if (bus.bank_e_valid_o !== exp_v) begin errors++; $display("FAIL rnd_e_valid n=%0d: got %b expected %b", n, bus.bank_e_valid_o, exp_v); end
         checks++; if (bus.up_e_ready_o !== erdy[tgt]) begin errors++; $display("FAIL rnd_e_ready n=%0d: got %b expected %b", n, bus.up_e_ready_o, erdy[tgt]); end
      end
   endtask

   // D merge with random bank traffic: each bank holds one message and keeps
   // it valid until all its beats are taken; the model owns the RR order.
   task automatic test_random_d();
      int d_left [NBANKS];
      logic [D_W-1:0] d_msg [NBANKS];
      logic [D_W-1:0] em, t;
      int cur, ptr, g, op, sz;
      logic dr, ev;
      do_reset();
      cur = -1; ptr = 0;
      for (int b = 0; b < NBANKS; b++) begin d_left[b] = 0; d_msg[b] = '0; end
      for (int n = 0; n < 1500; n++) begin
         tick();
         for (int b = 0; b < NBANKS; b++) begin
            if (d_left[b] == 0 && $urandom_range(0, 3) == 0) begin
               op = $urandom_range(0, 7);
               sz = $urandom_range(0, 6);
               d_msg[b]  = mk_d(op, sz, $urandom_range(0, 15));
               d_left[b] = (op == 1 || op == 5) ? beats(sz) : 1;
            end
            bus.bank_d_valid_i[b] = (d_left[b] != 0);
            bus.bank_d_msg_i[b*D_W +: D_W] = d_msg[b];
         end
         dr = ($urandom_range(0, 2) != 0);
         bus.up_d_ready_i = dr;
         #1;
         g = cur;
         if (g < 0) begin
            for (int k = 0; k < NBANKS; k++)
               if (g < 0 && d_left[(ptr + k) % NBANKS] != 0) g = (ptr + k) % NBANKS;
         end
         ev = (g >= 0);
         checks++; if (bus.up_d_valid_o !== ev) begin errors++; $display("FAIL rnd_d_valid n=%0d: got %b expected %b", n, bus.up_d_valid_o, ev); end
         checks++; if (bus.bank_d_ready_o !== ((ev && dr) ? 4'(1 << g) : 4'h0)) begin errors++; $display("FAIL rnd_d_ready n=%0d: got %b expected bank %0d rdy %b", n, bus.bank_d_ready_o, g, dr); end
         if (ev) begin
            em = d_msg[g];
            em[10:9] = 2'(g);
            checks++; if (bus.up_d_msg_o !== em) begin errors++; $display("FAIL rnd_d_msg n=%0d: got %h expected %h", n, bus.up_d_msg_o, em); end
            if (dr) begin
               d_left[g]--;
               if (d_left[g] == 0) begin
                  cur = -1;
                  ptr = (g + 1) % NBANKS;
               end else begin
                  cur = g;
                  t = mk_d(0, 0, 0);
                  t[10:0] = d_msg[g][10:0];
                  d_msg[g] = t;
               end
            end else begin
               cur = g;
            end
         end
      end
   endtask

   initial begin
      set_idle();
      test_reset();
      test_a_get();
      test_c_burst();
      test_d_pair();
      test_e();
      test_reset_midburst();
      test_random_ac_e();
      test_random_d();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/tl_bank_router.md
Name: tl_bank_router

Overview:
- Routes one coherent TileLink client-side socket (A/C/D/E) onto NBANKS address-interleaved L2 banks.
- Enables a banked L2 behind the existing N-client socket, scaling L2 bandwidth with bank count.
- A/C requests are routed by line address, with multi-beat bursts locked to one bank.
- D responses are merged by a round-robin arbiter with burst locking; D sink is tagged with the bank index, and E is routed back on that tag.

Parameters:
NBANKS, 4, number of L2 banks; power of 2, >=2; BANK_W = clog2(NBANKS)
ADDR_W, 64, address width
SINK_W, 4, D/E sink width; the top BANK_W bits are owned by the router
LINE_OFF, 6, log2 line bytes; bank = address[LINE_OFF +: BANK_W]
BEAT_LG, 3, log2 bytes per data beat
A_W, 160, packed A message width (>= 7+ADDR_W)
C_W, 152, packed C message width (>= 7+ADDR_W)
D_W, 80, packed D message width (>= 7+SINK_W)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
up_a_valid_i  in  1  client A valid
up_a_ready_o  out  1  client A ready
up_a_msg_i  in  A_W  A message: [2:0] opcode, [6:3] size, [ADDR_W+6:7] address, rest opaque
bank_a_valid_o  out  NBANKS  per-bank A valid
bank_a_ready_i  in  NBANKS  per-bank A ready
bank_a_msg_o  out  A_W  up_a_msg_i broadcast to all banks
up_c_valid_i  in  1  client C valid
up_c_ready_o  out  1  client C ready
up_c_msg_i  in  C_W  C message, same field layout as A
bank_c_valid_o  out  NBANKS  per-bank C valid
bank_c_ready_i  in  NBANKS  per-bank C ready
bank_c_msg_o  out  C_W  up_c_msg_i broadcast
bank_d_valid_i  in  NBANKS  per-bank D valid
bank_d_ready_o  out  NBANKS  per-bank D ready
bank_d_msg_i  in  NBANKS*D_W  D messages: [2:0] opcode, [6:3] size, [SINK_W+6:7] sink, rest opaque
up_d_valid_o  out  1  merged D valid
up_d_ready_i  in  1  client D ready
up_d_msg_o  out  D_W  granted message with sink top BANK_W bits replaced by the bank index
up_e_valid_i  in  1  client E valid
up_e_ready_o  out  1  client E ready
up_e_sink_i  in  SINK_W  E sink
bank_e_valid_o  out  NBANKS  per-bank E valid
bank_e_ready_i  in  NBANKS  per-bank E ready
bank_e_sink_o  out  SINK_W  up_e_sink_i broadcast

Behaviour:
- Zero-latency datapath: no buffering, valid and ready paths are combinational.
- State: A lock, C lock, D lock/hold, beat counters (8 bits), D round-robin pointer.
- Reset (asserted):
  - All *_valid_o and *_ready_o forced to 0.
  - Locks cleared, counters 0, RR pointer 0.
  - Reset mid-burst abandons the burst; no resume after release.
- beats(size) = (size > BEAT_LG) ? 1 << (size - BEAT_LG) : 1.
- Data-bearing opcodes:
  - A: 0 PutFull, 1 PutPartial.
  - C: 5 ProbeAckData, 7 ReleaseData.
  - D: 1 AccessAckData, 5 GrantData.
  - All other opcodes are single-beat.
- A routing:
  - Unlocked: target = address bank bits; bank_a_valid_o is one-hot on target; up_a_ready_o = bank_a_ready_i[target].
  - On the first-beat handshake of a data-bearing message with beats > 1: lock the target and load the counter with beats - 1.
  - Following beats go to the locked bank regardless of their address field.
  - Lock clears on the last-beat handshake; the next beat is routed unlocked in the next cycle.
- C routing: identical to A, with an independent lock and counter; A and C may target different banks in the same cycle.
- D merge:
  - Idle: grant the first valid bank at or after the RR pointer.
  - Once up_d_valid_o is high without up_d_ready_i, the grant is held (valid/msg stable) until handshake.
  - Multi-beat data messages lock the grant until the last beat.
  - On message completion the pointer becomes grant + 1 (mod NBANKS).
  - bank_d_ready_o is only asserted to the granted bank, equal to up_d_ready_i.
- D sink tag: up_d_msg_o sink = {grant index, bank sink low SINK_W-BANK_W bits}; banks use only the low bits.
- E routing: target = up_e_sink_i[SINK_W-1 -: BANK_W]; one-hot valid; ready from target; sink passed unmodified.
- A/C bursts never interleave across banks; D beats never interleave across messages.

Test Plan:
1. A Get (opcode 4), size 6, address 0x1040, bank_a_ready_i=4'b0010 -> bank_a_valid_o=4'b0010, up_a_ready_o=1, handshake in the same cycle.
2. C ReleaseData, size 6, address 0x00C0, 8 beats; beats 2-8 carry address 0x0 -> all 8 beats reach bank 3 only; a Release to 0x0 in the following cycle goes to bank 0.
3. Banks 0 and 2 issue GrantData size 6 together, pointer 0; bank 2 sink 4'h1 -> 8 bank-0 beats, then 8 bank-2 beats with output sink 4'h9; no interleave; pointer ends at 3.
4. Bank 1 D valid with up_d_ready_i=0 for 5 cycles; bank 0 raises valid in cycle 2 -> output holds the bank-1 message unchanged, bank 0 is served after.
5. E with up_e_sink_i=4'hC -> bank_e_valid_o=4'b1000; ready tracks bank_e_ready_i[3].
6. rst_i asserted at beat 3 of a bank-1 GrantData -> all valid/ready outputs 0 immediately; after release, a new bank-2 AccessAck is granted first (idle, pointer 0 scan).
